// File: rtl/ej32_pkg.sv
// Shared types and helpers for the eJ32 memory-port arbiter.
package ej32_pkg;

  typedef enum logic [1:0] {IDLE, BURST, TAIL} arb_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_S, SZ_W} ls_sz_t;

  // Encoding 3 is not a named size and falls through to a word.
  function automatic int unsigned ls_len(ls_sz_t sz);
    case (sz)
      SZ_B:    return 1;
      SZ_S:    return 2;
      default: return 4;
    endcase
  endfunction

  // Byte idx of a right-aligned word, idx 0 being the least-significant byte.
  function automatic logic [7:0] byte_at(logic [31:0] w, logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/ej32_arb_pick.sv
// Fetch vs load/store winner select; round-robin pointer only when EJ32_ARB_RR_EN is defined.
module ej32_arb_pick (
`ifdef EJ32_ARB_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic if_req,
  input  logic ls_req,
  output logic if_win,
  output logic ls_win
);

`ifdef EJ32_ARB_RR_EN
  logic ls_last_q;
  logic conflict;

  assign conflict = en & if_req & ls_req;
  // Reset value means "IF won last", so the first conflict goes to LS.
  assign ls_win   = en & ls_req & (~if_req | ~ls_last_q);
  assign if_win   = en & if_req & ~ls_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ls_last_q <= 1'b0;
    end else if (conflict) begin
      ls_last_q <= ls_win;
    end
  end
`else
  assign ls_win = en & ls_req;
  assign if_win = en & if_req & ~ls_req;
`endif

endmodule

// File: rtl/ej32_mem_arb.sv
// Byte-wide SRAM arbiter/sequencer: single-byte fetches and big-endian LS bursts.
// Round-robin arbitration is selected with EJ32_ARB_RR_EN; fixed LS priority otherwise.
module ej32_mem_arb
  import ej32_pkg::*;
#(
  parameter int unsigned AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_vld,
  output logic [7:0]    if_data,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [1:0]    ls_sz,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          ls_gnt,
  output logic          ls_done,
  output logic [31:0]   ls_rdata,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  arb_state_t    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    last_q, last_d;   // index of the final byte, N-1
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rd_pend_q, rd_pend_d;
  logic          done_q;
  logic          if_vld_q;
  logic          if_win, ls_win;
  logic [1:0]    req_last;

  assign req_last = 2'(ls_len(ls_sz_t'(ls_sz)) - 1);

  ej32_arb_pick u_pick (
`ifdef EJ32_ARB_RR_EN
    .clk    (clk),
    .rst    (rst),
`endif
    .en     ((state_q == IDLE) & rst),
    .if_req (if_req),
    .ls_req (ls_req),
    .if_win (if_win),
    .ls_win (ls_win)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_pend_d = 1'b0;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (ls_win) begin
          ls_gnt    = 1'b1;
          mem_cs    = 1'b1;
          mem_we    = ls_we;
          mem_addr  = ls_addr;
          mem_wdata = ls_we ? byte_at(ls_wdata, req_last) : 8'h00;
          rd_pend_d = ~ls_we;
          we_d      = ls_we;
          addr_d    = ls_addr;
          wdata_d   = ls_wdata;
          last_d    = req_last;
          if (req_last == 2'd0) begin
            state_d = TAIL;
            cnt_d   = 2'd0;
          end else begin
            state_d = BURST;
            cnt_d   = 2'd1;
          end
        end else if (if_win) begin
          if_gnt   = 1'b1;
          mem_cs   = 1'b1;
          mem_addr = if_addr;
        end
      end
      BURST: begin
        mem_cs    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q + {{(AW-2){1'b0}}, cnt_q};
        mem_wdata = we_q ? byte_at(wdata_q, last_q - cnt_q) : 8'h00;
        rd_pend_d = ~we_q;
        if (cnt_q == last_q) begin
          state_d = TAIL;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      TAIL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Load bytes arrive one cycle after issue and shift in MSB first.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_pend_q) begin
      rdata_d = {rdata_q[23:0], mem_rdata};
    end
    if (ls_gnt) begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      last_q    <= 2'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_pend_q <= 1'b0;
      done_q    <= 1'b0;
      if_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_pend_q <= rd_pend_d;
      done_q    <= (state_q == TAIL);
      if_vld_q  <= if_gnt;
    end
  end

  assign if_vld   = if_vld_q;
  assign if_data  = if_vld_q ? mem_rdata : 8'h00;
  assign ls_done  = done_q;
  assign ls_rdata = rdata_q;

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Directed self-checking bench for ej32_mem_arb with a synchronous byte SRAM model.
module tb_ej32_mem_arb;

  localparam int unsigned AW = 17;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_vld;
  logic [7:0]    if_data;
  logic          ls_req;
  logic          ls_we;
  logic [1:0]    ls_sz;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata;
  logic          ls_gnt;
  logic          ls_done;
  logic [31:0]   ls_rdata;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [7:0] mem [0:(1<<AW)-1];

  int n_chk;
  int n_pass;
  int n_fail;

  ej32_mem_arb #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_vld    (if_vld),
    .if_data   (if_data),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_sz     (ls_sz),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_done   (ls_done),
    .ls_rdata  (ls_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: preload, then one access per rising edge.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[17'h100] = 8'hB2;
    mem[17'h101] = 8'h10;
    mem[17'h102] = 8'h04;
    mem[17'h103] = 8'h60;
    mem[17'h200] = 8'hDE;
    mem[17'h201] = 8'hAD;
    mem[17'h202] = 8'hBE;
    mem[17'h203] = 8'hEF;
    mem[17'h300] = 8'h5A;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_cs) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata     <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns just after a rising edge; inputs are driven here, checks #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fbytes [4];

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    fbytes = '{8'hB2, 8'h10, 8'h04, 8'h60};
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_sz = 2'd0; ls_addr = '0; ls_wdata = '0;

    #2;
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_ls_gnt", {31'd0, ls_gnt}, 32'd0);
    chk("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
    chk("rst_ls_done", {31'd0, ls_done}, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_if_vld", {31'd0, if_vld}, 32'd0);

    tick(); rst = 1'b1;

    // Fetch stream 0x100..0x103, back to back.
    for (int i = 0; i < 5; i++) begin
      tick();
      if_req  = (i < 4);
      if_addr = 17'h100 + AW'(i);
      #1;
      if (i < 4) begin
        chk("fs_gnt", {31'd0, if_gnt}, 32'd1);
        chk("fs_addr", {15'd0, mem_addr}, 32'h100 + 32'(i));
      end else begin
        chk("fs_gnt_off", {31'd0, if_gnt}, 32'd0);
      end
      if (i > 0) begin
        chk("fs_vld", {31'd0, if_vld}, 32'd1);
        chk("fs_data", {24'd0, if_data}, {24'd0, fbytes[i-1]});
      end else begin
        chk("fs_vld0", {31'd0, if_vld}, 32'd0);
      end
    end

    // Word load at 0x200 with a fetch waiting.
    tick();
    ls_req = 1'b1; ls_we = 1'b0; ls_sz = 2'd2; ls_addr = 17'h200;
    if_req = 1'b1; if_addr = 17'h103;
    #1;
    chk("wl_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("wl_if_held", {31'd0, if_gnt}, 32'd0);
    chk("wl_addr0", {15'd0, mem_addr}, 32'h200);
    for (int k = 1; k <= 4; k++) begin
      tick();
      ls_req = 1'b0;
      #1;
      chk("wl_if_held", {31'd0, if_gnt}, 32'd0);
      chk("wl_cs", {31'd0, mem_cs}, (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) chk("wl_addr", {15'd0, mem_addr}, 32'h200 + 32'(k));
      chk("wl_no_done", {31'd0, ls_done}, 32'd0);
    end
    tick(); #1;
    chk("wl_done", {31'd0, ls_done}, 32'd1);
    chk("wl_rdata", ls_rdata, 32'hDEADBEEF);
    chk("wl_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick(); if_req = 1'b0; #1;
    chk("wl_done_pulse", {31'd0, ls_done}, 32'd0);
    chk("wl_rdata_hold", ls_rdata, 32'hDEADBEEF);
    chk("wl_if_data", {24'd0, if_data}, 32'h60);

    // Short store wrapping past the top of memory.
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_sz = 2'd1; ls_addr = 17'h1FFFF; ls_wdata = 32'h12345678;
    #1;
    chk("ss_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("ss_we0", {31'd0, mem_we}, 32'd1);
    chk("ss_addr0", {15'd0, mem_addr}, 32'h1FFFF);
    chk("ss_wd0", {24'd0, mem_wdata}, 32'h56);
    tick(); ls_req = 1'b0; #1;
    chk("ss_we1", {31'd0, mem_we}, 32'd1);
    chk("ss_addr1", {15'd0, mem_addr}, 32'h0);
    chk("ss_wd1", {24'd0, mem_wdata}, 32'h78);
    tick(); #1;
    chk("ss_tail_cs", {31'd0, mem_cs}, 32'd0);
    chk("ss_no_done", {31'd0, ls_done}, 32'd0);
    tick(); #1;
    chk("ss_done", {31'd0, ls_done}, 32'd1);
    chk("ss_rdata", ls_rdata, 32'd0);
    chk("ss_mem_hi", {24'd0, mem[17'h1FFFF]}, 32'h56);
    chk("ss_mem_lo", {24'd0, mem[17'h00000]}, 32'h78);

    // Two conflicts between a fetch and a byte load.
    tick();
    if_req = 1'b1; if_addr = 17'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_sz = 2'd0; ls_addr = 17'h300;
    #1;
    chk("c1_ls_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("c1_if_gnt", {31'd0, if_gnt}, 32'd0);
    tick(); ls_req = 1'b0; #1;
    chk("c1_tail_cs", {31'd0, mem_cs}, 32'd0);
    tick(); ls_req = 1'b1; #1;
    chk("c1_done", {31'd0, ls_done}, 32'd1);
    chk("c1_rdata", ls_rdata, 32'h5A);
`ifdef EJ32_ARB_RR_EN
    chk("c2_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("c2_ls_gnt", {31'd0, ls_gnt}, 32'd0);
    tick(); if_req = 1'b0; #1;
    chk("c2_ls_after", {31'd0, ls_gnt}, 32'd1);
    chk("c2_if_data", {24'd0, if_data}, 32'hB2);
    tick(); ls_req = 1'b0; #1;
    tick(); #1;
    chk("c2_done", {31'd0, ls_done}, 32'd1);
    chk("c2_rdata", ls_rdata, 32'h5A);
`else
    chk("c2_ls_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("c2_if_gnt", {31'd0, if_gnt}, 32'd0);
    tick(); ls_req = 1'b0; #1;
    chk("c2_tail_if", {31'd0, if_gnt}, 32'd0);
    tick(); #1;
    chk("c2_done", {31'd0, ls_done}, 32'd1);
    chk("c2_rdata", ls_rdata, 32'h5A);
    chk("c2_if_after", {31'd0, if_gnt}, 32'd1);
    tick(); if_req = 1'b0; #1;
    chk("c2_if_data", {24'd0, if_data}, 32'hB2);
`endif

    // Reset in the middle of a word store.
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_sz = 2'd2; ls_addr = 17'h400; ls_wdata = 32'hA1B2C3D4;
    #1;
    chk("rs_gnt", {31'd0, ls_gnt}, 32'd1);
    tick(); ls_req = 1'b0; #1;
    chk("rs_wd1", {24'd0, mem_wdata}, 32'hB2);
    tick(); rst = 1'b0; #1;
    chk("rs_cs", {31'd0, mem_cs}, 32'd0);
    chk("rs_we", {31'd0, mem_we}, 32'd0);
    chk("rs_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rs_done", {31'd0, ls_done}, 32'd0);
    tick(); #1;
    chk("rs_done_held", {31'd0, ls_done}, 32'd0);
    tick(); rst = 1'b1; if_req = 1'b1; if_addr = 17'h101; #1;
    chk("rs_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("rs_no_done", {31'd0, ls_done}, 32'd0);
    tick(); if_req = 1'b0; #1;
    chk("rs_if_data", {24'd0, if_data}, 32'h10);
    chk("rs_no_done2", {31'd0, ls_done}, 32'd0);
    chk("rs_mem400", {24'd0, mem[17'h400]}, 32'hA1);
    chk("rs_mem401", {24'd0, mem[17'h401]}, 32'hB2);
    chk("rs_mem402", {24'd0, mem[17'h402]}, 32'h00);

    // Fetch at T, byte load at T+1.
    tick(); if_req = 1'b1; if_addr = 17'h102; #1;
    chk("fl_if_gnt", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_sz = 2'd0; ls_addr = 17'h300;
    #1;
    chk("fl_ls_gnt", {31'd0, ls_gnt}, 32'd1);
    chk("fl_if_vld", {31'd0, if_vld}, 32'd1);
    chk("fl_if_data", {24'd0, if_data}, 32'h04);
    tick(); ls_req = 1'b0; #1;
    tick(); #1;
    chk("fl_done", {31'd0, ls_done}, 32'd1);
    chk("fl_rdata", ls_rdata, 32'h5A);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
